// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared constants for the RV32M multiply controller.
//   MUL_XLEN        : default operand/result width
//   OP_*            : op_i encodings (funct3[1:0])
//   state_t         : controller FSM state encodings
// Optional feature macro used by mul_ctrl: MUL_FUSE_EN
// ---------------------------------------------------------------------------
package mul_pkg;

   localparam int MUL_XLEN = 32;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2,
      S_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/mul_sign_fix.sv
// ---------------------------------------------------------------------------
// mul_sign_fix
// Combinational sign correction of an unsigned 2*XLEN product followed by
// hi/lo half selection.
// Ports:
//   prod_i  in  2*XLEN  unsigned magnitude product
//   neg_i   in  1       negate the product (two's complement)
//   hi_i    in  1       1: select upper half, 0: lower half
//   prod_o  out 2*XLEN  signed-corrected product
//   half_o  out XLEN    selected half of prod_o
// ---------------------------------------------------------------------------
module mul_sign_fix
   import mul_pkg::*;
#(
   parameter int XLEN = MUL_XLEN
) (
   input  logic [2*XLEN-1:0] prod_i,
   input  logic              neg_i,
   input  logic              hi_i,
   output logic [2*XLEN-1:0] prod_o,
   output logic [XLEN-1:0]   half_o
);

   assign prod_o = neg_i ? (~prod_i + (2*XLEN)'(1)) : prod_i;
   assign half_o = hi_i ? prod_o[2*XLEN-1:XLEN] : prod_o[XLEN-1:0];

endmodule

// File: rtl/mul_ctrl.sv
// ---------------------------------------------------------------------------
// mul_ctrl
// RV32M multiply front/back-end between EXE issue and an unsigned shift-add
// multiplier core. Converts operands to magnitudes, holds the core request
// until its done pulse, sign-corrects the product and returns the selected
// half through a valid/ready handshake.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   flush_i                   abandon any in-flight op
//   valid_i/ready_o           op request handshake (ready_o only in S_IDLE)
//   op_i, rs1_i, rs2_i        op select and operands
//   valid_o/ready_i, result_o result handshake and rd value
//   mul_req_o, mul_a_o/b_o    core request level and operand magnitudes
//   mul_ready_i, mul_result_i core done pulse and unsigned product
// Macro MUL_FUSE_EN: keeps a tag of the last core op's operands/signedness
// and its signed product; a matching op skips the core.
// ---------------------------------------------------------------------------
module mul_ctrl
   import mul_pkg::*;
#(
   parameter int XLEN = MUL_XLEN
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [1:0]        op_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [XLEN-1:0]   result_o,
   output logic              mul_req_o,
   output logic [XLEN-1:0]   mul_a_o,
   output logic [XLEN-1:0]   mul_b_o,
   input  logic              mul_ready_i,
   input  logic [2*XLEN-1:0] mul_result_i
);

   state_t            state_q;
   logic              mul_req_q;
   logic              valid_q;
   logic [XLEN-1:0]   result_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic              neg_q;
   logic [1:0]        op_q;

   // Operand decode for the op presented at the input
   logic              sign_a_d, sign_b_d;
   logic [XLEN-1:0]   a_d, b_d;
   logic              fuse_hit;

   // Shared sign-fix datapath
   logic [2*XLEN-1:0] fix_in;
   logic              fix_neg;
   logic              fix_hi;
   logic [2*XLEN-1:0] fix_prod;
   logic [XLEN-1:0]   fix_half;

   always_comb begin
      sign_a_d = rs1_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU));
      sign_b_d = rs2_i[XLEN-1] & (op_i == OP_MULH);
      // 0x8000_0000 negates to itself, which is the correct unsigned magnitude
      a_d = sign_a_d ? (~rs1_i + XLEN'(1)) : rs1_i;
      b_d = sign_b_d ? (~rs2_i + XLEN'(1)) : rs2_i;
   end

`ifdef MUL_FUSE_EN
   logic              tag_vld_q;
   logic [XLEN-1:0]   tag_rs1_q, tag_rs2_q;
   logic              tag_sa_q, tag_sb_q;
   logic [2*XLEN-1:0] tag_prod_q;
   logic              key_sa, key_sb;

   always_comb begin
      // The low half is identical under any signedness, so a MUL looks up
      // as signed x signed: it then pairs with a preceding MULH but never
      // reuses a MULHU/MULHSU product of negative operands.
      key_sa   = (op_i == OP_MUL) ? rs1_i[XLEN-1] : sign_a_d;
      key_sb   = (op_i == OP_MUL) ? rs2_i[XLEN-1] : sign_b_d;
      fuse_hit = tag_vld_q && (rs1_i == tag_rs1_q) && (rs2_i == tag_rs2_q)
                 && (key_sa == tag_sa_q) && (key_sb == tag_sb_q);
   end

   // In S_IDLE the sign-fix unit serves the fuse lookup (stored product is
   // already signed); otherwise it corrects the core product.
   always_comb begin
      if (state_q == S_IDLE) begin
         fix_in  = tag_prod_q;
         fix_neg = 1'b0;
         fix_hi  = (op_i != OP_MUL);
      end else begin
         fix_in  = mul_result_i;
         fix_neg = neg_q;
         fix_hi  = (op_q != OP_MUL);
      end
   end
`else
   logic unused_fix_prod;

   assign fuse_hit        = 1'b0;
   assign fix_in          = mul_result_i;
   assign fix_neg         = neg_q;
   assign fix_hi          = (op_q != OP_MUL);
   assign unused_fix_prod = ^fix_prod;
`endif

   mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .prod_i (fix_in),
      .neg_i  (fix_neg),
      .hi_i   (fix_hi),
      .prod_o (fix_prod),
      .half_o (fix_half)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         mul_req_q  <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         neg_q      <= 1'b0;
         op_q       <= OP_MUL;
`ifdef MUL_FUSE_EN
         tag_vld_q  <= 1'b0;
         tag_rs1_q  <= '0;
         tag_rs2_q  <= '0;
         tag_sa_q   <= 1'b0;
         tag_sb_q   <= 1'b0;
         tag_prod_q <= '0;
`endif
      end else if (flush_i) begin
         // Flush wins over everything, including a same-cycle done pulse
         state_q   <= S_IDLE;
         mul_req_q <= 1'b0;
         valid_q   <= 1'b0;
`ifdef MUL_FUSE_EN
         tag_vld_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  a_q   <= a_d;
                  b_q   <= b_d;
                  neg_q <= sign_a_d ^ sign_b_d;
                  op_q  <= op_i;
                  if (fuse_hit) begin
                     result_q <= fix_half;
                     valid_q  <= 1'b1;
                     state_q  <= S_RESP;
                  end else begin
                     mul_req_q <= 1'b1;
                     state_q   <= S_REQ;
`ifdef MUL_FUSE_EN
                     // Tag becomes valid only once its product is captured
                     tag_vld_q <= 1'b0;
                     tag_rs1_q <= rs1_i;
                     tag_rs2_q <= rs2_i;
                     tag_sa_q  <= sign_a_d;
                     tag_sb_q  <= sign_b_d;
`endif
                  end
               end
            end
            S_REQ: begin
               if (mul_ready_i) begin
                  result_q  <= fix_half;
                  mul_req_q <= 1'b0;
                  state_q   <= S_DROP;
`ifdef MUL_FUSE_EN
                  tag_prod_q <= fix_prod;
                  tag_vld_q  <= 1'b1;
`endif
               end
            end
            S_DROP: begin
               valid_q <= 1'b1;
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_o   = (state_q == S_IDLE);
   assign valid_o   = valid_q;
   assign result_o  = result_q;
   assign mul_req_o = mul_req_q;
   assign mul_a_o   = a_q;
   assign mul_b_o   = b_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_ctrl
// Directed bench for mul_ctrl. The bench plays the multiplier core: it
// returns the product of the presented magnitudes after a chosen latency.
// Define MUL_FUSE_EN to also exercise the fuse path.
// ---------------------------------------------------------------------------
module tb_mul_ctrl;
   import mul_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  op_i;
   logic [31:0] rs1_i, rs2_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        mul_req_o;
   logic [31:0] mul_a_o, mul_b_o;
   logic        mul_ready_i;
   logic [63:0] mul_result_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   mul_ctrl #(.XLEN(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .op_i         (op_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .result_o     (result_o),
      .mul_req_o    (mul_req_o),
      .mul_a_o      (mul_a_o),
      .mul_b_o      (mul_b_o),
      .mul_ready_i  (mul_ready_i),
      .mul_result_i (mul_result_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full core-path transaction: accept, hold request for lat cycles,
   // done pulse, drop cycle, response held for hold cycles, then accepted.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input int lat, input logic [31:0] exp, input int hold);
      op_i = op; rs1_i = a; rs2_i = b; valid_i = 1'b1;
      chk({tag, " ready_o idle"}, 64'(ready_o), 64'd1);
      tick();
      valid_i = 1'b0;
      chk({tag, " mul_req_o"}, 64'(mul_req_o), 64'd1);
      chk({tag, " mul_a_o"}, 64'(mul_a_o), 64'(ea));
      chk({tag, " mul_b_o"}, 64'(mul_b_o), 64'(eb));
      repeat (lat - 1) tick();
      chk({tag, " mul_req_o held"}, 64'(mul_req_o), 64'd1);
      mul_ready_i  = 1'b1;
      mul_result_i = {32'd0, mul_a_o} * {32'd0, mul_b_o};
      tick();
      mul_ready_i  = 1'b0;
      mul_result_i = 64'hDEAD_BEEF_DEAD_BEEF;
      chk({tag, " mul_req_o drop"}, 64'(mul_req_o), 64'd0);
      chk({tag, " valid_o drop"}, 64'(valid_o), 64'd0);
      tick();
      chk({tag, " valid_o"}, 64'(valid_o), 64'd1);
      chk({tag, " result_o"}, 64'(result_o), 64'(exp));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " valid_o hold"}, 64'(valid_o), 64'd1);
         chk({tag, " result_o hold"}, 64'(result_o), 64'(exp));
      end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk({tag, " valid_o done"}, 64'(valid_o), 64'd0);
      chk({tag, " ready_o done"}, 64'(ready_o), 64'd1);
      $display("[TB] %s op=%0d rs1=%h rs2=%h expect=%h", tag, op, a, b, exp);
   endtask

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = OP_MUL;
      rs1_i = '0; rs2_i = '0; ready_i = 1'b0; mul_ready_i = 1'b0;
      mul_result_i = '0;
      repeat (3) tick();
      chk("reset valid_o",   64'(valid_o),   64'd0);
      chk("reset mul_req_o", 64'(mul_req_o), 64'd0);
      chk("reset result_o",  64'(result_o),  64'd0);
      chk("reset mul_a_o",   64'(mul_a_o),   64'd0);
      chk("reset mul_b_o",   64'(mul_b_o),   64'd0);
      chk("reset ready_o",   64'(ready_o),   64'd1);
      $display("[TB] reset checked");
      rst_ni = 1'b1;
      tick();

      run_op("mul_7x6",        OP_MUL,    32'd7,         32'd6,         32'd7,         32'd6,         34, 32'd42,        0);
      run_op("mulh_m1xm1",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd1,         34, 32'd0,         0);
      run_op("mulhu_ffxff",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 1);
      run_op("mulhsu_min",     OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 0);
      run_op("mulh_minxmin",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 0);
      run_op("mul_zero",       OP_MUL,    32'd0,         32'h1234,      32'd0,         32'h1234,      2,  32'd0,         5);
      run_op("mulh_0xm1",      OP_MULH,   32'd0,         32'hFFFF_FFFF, 32'd0,         32'd1,         2,  32'd0,         0);

      // Flush in S_REQ with a coincident done pulse: no result may appear
      op_i = OP_MUL; rs1_i = 32'd9; rs2_i = 32'd9; valid_i = 1'b1;
      tick();
      op_i = OP_MULHU; rs1_i = 32'd1; rs2_i = 32'd2;
      chk("busy ready_o", 64'(ready_o), 64'd0);
      tick();
      valid_i = 1'b0;
      chk("busy mul_a_o", 64'(mul_a_o), 64'd9);
      flush_i = 1'b1; mul_ready_i = 1'b1; mul_result_i = 64'd81;
      tick();
      flush_i = 1'b0; mul_ready_i = 1'b0; mul_result_i = '0;
      chk("flush mul_req_o", 64'(mul_req_o), 64'd0);
      chk("flush valid_o",   64'(valid_o),   64'd0);
      chk("flush ready_o",   64'(ready_o),   64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush no valid_o", 64'(valid_o), 64'd0);
      end
      $display("[TB] flush in S_REQ checked");
      run_op("mul_3x5",        OP_MUL,    32'd3,         32'd5,         32'd3,         32'd5,         10, 32'd15,        0);

`ifdef MUL_FUSE_EN
      run_op("mulh_m3x5",      OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'd3,         32'd5,         34, 32'hFFFF_FFFF, 0);
      op_i = OP_MUL; rs1_i = 32'hFFFF_FFFD; rs2_i = 32'd5; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk("fuse valid_o",   64'(valid_o),   64'd1);
      chk("fuse mul_req_o", 64'(mul_req_o), 64'd0);
      chk("fuse result_o",  64'(result_o),  64'hFFFF_FFF1);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("fuse done ready_o", 64'(ready_o), 64'd1);
      $display("[TB] fuse hit MUL after MULH checked");
      run_op("mulhu_m3x5",     OP_MULHU,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD, 32'd5,         20, 32'd4,         0);
      run_op("mul_m3x5_miss",  OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD, 32'd5,         20, 32'hFFFF_FFF1, 0);
`else
      run_op("mulh_m3x5",      OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'd3,         32'd5,         34, 32'hFFFF_FFFF, 0);
      run_op("mul_m3x5",       OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD, 32'd5,         34, 32'hFFFF_FFF1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
